// File: rtl/gaus_log_interp_tab.sv
// ---------------------------------------------------------------------------
// gaus_log_interp_tab
//
// Multi-channel evaluator of sqrt(-2*ln(u)) for a Box-Muller AWGN generator.
// u = iaddr_c / 2^pIW. The top pTAW bits of each channel word index a table
// of 2^pTAW+1 points built at elaboration. The low FW = pIW-pTAW bits
// optionally interpolate linearly toward the next table point.
//
// Optional feature macro: GAUS_LOG_TAB_INTERP_EN
//   defined   : linear interpolation; S3 holds a pDW x FW multiplier.
//   undefined : truncating lookup y = T[i]; S3 is a plain register stage.
// Latency is 4 enabled cycles in both builds.
//
// Ports
//   iclk     in   clock
//   ireset   in   asynchronous active-low reset
//   iclkena  in   global clock enable (0 freezes every register)
//   ival     in   input sample valid
//   iaddr    in   pNCH*pIW, channel c at [c*pIW +: pIW]
//   oval     out  output valid
//   odat     out  pNCH*pDW unsigned, channel c at [c*pDW +: pDW], LSB 2^-pFRAC
//   osat     out  pNCH, channel result came from table segment 0
// ---------------------------------------------------------------------------
module gaus_log_interp_tab #(
    parameter int pNCH  = 2,
    parameter int pIW   = 16,
    parameter int pTAW  = 9,
    parameter int pDW   = 18,
    parameter int pFRAC = 15
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic                 ival,
    input  logic [pNCH*pIW-1:0]  iaddr,
    output logic                 oval,
    output logic [pNCH*pDW-1:0]  odat,
    output logic [pNCH-1:0]      osat
);

    localparam int FW  = pIW - pTAW;
    localparam int NPT = 2 ** pTAW;
    localparam int QB  = 30;            // fractional bits of the fixed-point log math

    // -----------------------------------------------------------------------
    // Table point T[j] = round(2^pFRAC * sqrt(-2*ln(j/2^pTAW))), saturated.
    // Computed with 64-bit fixed-point integers so that every tool can
    // evaluate it at elaboration without real-valued math functions:
    //   ln(j) = k*ln2 + ln(m), j = m*2^k, m in [1,2)
    //   ln(m) = 2*atanh(z), z = (m-1)/(m+1) <= 1/3, odd power series
    // The square root is taken on a value scaled by 4 so the integer root
    // carries one extra bit used for round-half-up.
    // -----------------------------------------------------------------------
    function automatic logic [pDW-1:0] tab_val(input int j);
        logic [63:0] one_q, ln2_q, m_q, z_q, z2_q, term, sum, ln_q, v_q;
        logic [63:0] w, res, bitv, ymax, yv;
        int          k, sh;
        ymax = (64'd1 << pDW) - 64'd1;
        if (j <= 0) begin
            yv = ymax;
        end else if (j >= NPT) begin
            yv = 64'd0;
        end else begin
            one_q = 64'd1 << QB;
            ln2_q = 64'd744261118;                  // round(ln2 * 2^30)
            k = 0;
            while ((j >> (k + 1)) != 0) k = k + 1;
            m_q  = (64'(j) << QB) >> k;
            z_q  = ((m_q - one_q) << QB) / (m_q + one_q);
            z2_q = (z_q * z_q) >> QB;
            term = z_q;
            sum  = 64'd0;
            for (int n = 1; n < 40; n = n + 2) begin
                sum  = sum + term / 64'(n);
                term = (term * z2_q) >> QB;
            end
            ln_q = 64'(k) * ln2_q + (sum << 1);
            v_q  = (64'(pTAW) * ln2_q - ln_q) << 1;  // -2*ln(j/2^pTAW) in Q30
            sh   = 2 * pFRAC + 2 - QB;
            w    = (sh >= 0) ? (v_q << sh) : (v_q >> (-sh));
            // bitwise integer square root
            res  = 64'd0;
            bitv = 64'd1 << 62;
            while (bitv > w) bitv = bitv >> 2;
            while (bitv != 64'd0) begin
                if (w >= res + bitv) begin
                    w   = w - (res + bitv);
                    res = (res >> 1) + bitv;
                end else begin
                    res = res >> 1;
                end
                bitv = bitv >> 2;
            end
            yv = (res + 64'd1) >> 1;
            if (yv > ymax) yv = ymax;
        end
        return yv[pDW-1:0];
    endfunction

    // Constant ROM image shared by all channels.
    logic [pDW-1:0] tab [0:NPT];

    genvar gi;
    generate
        for (gi = 0; gi <= NPT; gi++) begin : g_tab
            localparam logic [pDW-1:0] TV = tab_val(gi);
            assign tab[gi] = TV;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Valid chain. Data stages advance on every enabled cycle; ival only
    // qualifies the matching output slot.
    // -----------------------------------------------------------------------
    logic val_s1_reg, val_s2_reg, val_s3_reg, oval_reg;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            val_s1_reg <= 1'b0;
            val_s2_reg <= 1'b0;
            val_s3_reg <= 1'b0;
            oval_reg   <= 1'b0;
        end else if (iclkena) begin
            val_s1_reg <= ival;
            val_s2_reg <= val_s1_reg;
            val_s3_reg <= val_s2_reg;
            oval_reg   <= val_s3_reg;
        end
    end

    assign oval = oval_reg;

    // -----------------------------------------------------------------------
    // Per-channel datapath
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < pNCH; gi++) begin : g_ch
            logic [pIW-1:0]  addr_s1_reg;
            logic [pTAW-1:0] idx;
            logic [pDW-1:0]  t0_s2_reg, t0_s3_reg, dat_s4_reg;
            logic            sat_s2_reg, sat_s3_reg, sat_s4_reg;
            logic [pDW-1:0]  dec_s3;     // amount taken off T[i] in S4

            assign idx = addr_s1_reg[pIW-1 -: pTAW];

            always_ff @(posedge iclk or negedge ireset) begin
                if (!ireset) begin
                    addr_s1_reg <= '0;
                    t0_s2_reg   <= '0;
                    sat_s2_reg  <= 1'b0;
                    t0_s3_reg   <= '0;
                    sat_s3_reg  <= 1'b0;
                    dat_s4_reg  <= '0;
                    sat_s4_reg  <= 1'b0;
                end else if (iclkena) begin
                    addr_s1_reg <= iaddr[gi*pIW +: pIW];
                    t0_s2_reg   <= tab[{1'b0, idx}];
                    sat_s2_reg  <= (idx == '0);
                    t0_s3_reg   <= t0_s2_reg;
                    sat_s3_reg  <= sat_s2_reg;
                    dat_s4_reg  <= t0_s3_reg - dec_s3;
                    sat_s4_reg  <= sat_s3_reg;
                end
            end

`ifdef GAUS_LOG_TAB_INTERP_EN
            if (FW > 0) begin : g_interp
                localparam logic [pDW+FW-1:0] HALF = (pDW + FW)'(1) << (FW - 1);
                logic [pTAW:0]      idx_nx;
                logic [pDW-1:0]     t1_s2_reg;
                logic [FW-1:0]      f_s2_reg;
                logic [pDW+FW-1:0]  p_s3_reg;
                logic [pDW-1:0]     d;

                assign idx_nx = {1'b0, idx} + 1'b1;
                // T is non-increasing, so the step never wraps.
                assign d = t0_s2_reg - t1_s2_reg;

                always_ff @(posedge iclk or negedge ireset) begin
                    if (!ireset) begin
                        t1_s2_reg <= '0;
                        f_s2_reg  <= '0;
                        p_s3_reg  <= '0;
                    end else if (iclkena) begin
                        t1_s2_reg <= tab[idx_nx];
                        f_s2_reg  <= addr_s1_reg[FW-1:0];
                        p_s3_reg  <= (pDW + FW)'(d) * (pDW + FW)'(f_s2_reg);
                    end
                end

                // p <= d*(2^FW-1), so the rounded quotient never exceeds d
                // and the S4 subtraction cannot underflow.
                assign dec_s3 = pDW'((p_s3_reg + HALF) >> FW);
            end else begin : g_nointerp
                assign dec_s3 = '0;
            end
`else
            assign dec_s3 = '0;
            if (FW > 0) begin : g_frac_unused
                logic unused_frac;
                assign unused_frac = ^addr_s1_reg[FW-1:0];
            end
`endif

            assign odat[gi*pDW +: pDW] = dat_s4_reg;
            assign osat[gi]            = sat_s4_reg;
        end
    endgenerate

endmodule

// File: tb/tb_gaus_log_interp_tab.sv
// ---------------------------------------------------------------------------
// tb_gaus_log_interp_tab
//
// Scoreboard bench for gaus_log_interp_tab (default parameters). The
// stimulus process pushes the expected result and the enabled-edge number
// at which it must appear; the monitor checks oval/odat/osat on every
// enabled edge. Works for both builds of GAUS_LOG_TAB_INTERP_EN.
// ---------------------------------------------------------------------------
module tb_gaus_log_interp_tab;

    localparam int NCH  = 2;
    localparam int IW   = 16;
    localparam int TAW  = 9;
    localparam int DW   = 18;
    localparam int FRAC = 15;
    localparam int FW   = IW - TAW;
    localparam int NPT  = 2 ** TAW;
    localparam int YMAX = 2 ** DW - 1;
`ifdef GAUS_LOG_TAB_INTERP_EN
    localparam int Y_FFFF = 16;        // 2049 - 2033
`else
    localparam int Y_FFFF = 2049;      // T[511]
`endif

    logic                iclk    = 1'b0;
    logic                ireset  = 1'b1;
    logic                iclkena = 1'b0;
    logic                ival    = 1'b0;
    logic [NCH*IW-1:0]   iaddr   = '0;
    logic                oval;
    logic [NCH*DW-1:0]   odat;
    logic [NCH-1:0]      osat;

    gaus_log_interp_tab #(
        .pNCH(NCH), .pIW(IW), .pTAW(TAW), .pDW(DW), .pFRAC(FRAC)
    ) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
        .iaddr(iaddr), .oval(oval), .odat(odat), .osat(osat)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int edge_no;
        int a0, a1;
        int y0, y1;
        bit s0, s1;
    } exp_t;

    exp_t q[$];
    int   tab_m [0:NPT];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   en_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, en_cnt);
        end
    endtask

    function automatic int model_y(input int a);
        int i, f, d;
        i = a >> FW;
        f = a & ((1 << FW) - 1);
`ifdef GAUS_LOG_TAB_INTERP_EN
        d = tab_m[i] - tab_m[i + 1];
        return tab_m[i] - ((d * f + (1 << (FW - 1))) >> FW);
`else
        f = f;
        d = 0;
        return tab_m[i] + d;
`endif
    endfunction

    // Hand-computed results for the directed boundary addresses.
    function automatic int hand_y(input int a);
        case (a)
            16'h0000: return YMAX;
            16'h8000: return 38581;
            16'hFF80: return 2049;
            default:  return Y_FFFF;
        endcase
    endfunction

    // Set inputs for the coming edge and log the expectation if captured.
    task automatic apply(input bit v, input bit en, input int a0, input int a1, input bit hand);
        exp_t e;
        ival    = v;
        iclkena = en;
        iaddr   = {a1[IW-1:0], a0[IW-1:0]};
        if (v && en && ireset) begin
            e.edge_no = en_cnt + 4;
            e.a0 = a0;
            e.a1 = a1;
            e.y0 = hand ? hand_y(a0) : model_y(a0);
            e.y1 = hand ? hand_y(a1) : model_y(a1);
            e.s0 = ((a0 >> FW) == 0);
            e.s1 = ((a1 >> FW) == 0);
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input bit en, input int a0, input int a1, input bit hand);
        @(posedge iclk);
        #2;
        apply(v, en, a0, a1, hand);
    endtask

    // ---------------------------------------------------------------- monitor
    int last_a0 = -10, last_y0 = 0, last_a1 = -10, last_y1 = 0;

    always @(posedge iclk) begin
        bit   en_s;
        bit   exp_v;
        exp_t e;
        en_s = iclkena && ireset;
        #1;
        if (en_s) begin
            en_cnt++;
            exp_v = (q.size() > 0) && (q[0].edge_no == en_cnt);
            check("oval", int'(oval), int'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                if (oval) begin
                    check("odat0", int'(odat[DW-1:0]), e.y0);
                    check("odat1", int'(odat[2*DW-1:DW]), e.y1);
                    check("osat0", int'(osat[0]), int'(e.s0));
                    check("osat1", int'(osat[1]), int'(e.s1));
                    if (e.a0 == last_a0 + 1)
                        check("mono0", int'(int'(odat[DW-1:0]) > last_y0), 0);
                    if (e.a1 == last_a1 - 1)
                        check("mono1", int'(int'(odat[2*DW-1:DW]) < last_y1), 0);
                    last_a0 = e.a0;
                    last_y0 = int'(odat[DW-1:0]);
                    last_a1 = e.a1;
                    last_y1 = int'(odat[2*DW-1:DW]);
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        real x;
        int  v;
        for (int j = 0; j <= NPT; j++) begin
            if (j == 0) begin
                tab_m[j] = YMAX;
            end else if (j == NPT) begin
                tab_m[j] = 0;
            end else begin
                x = (2.0 ** FRAC) * $sqrt(-2.0 * $ln(real'(j) / real'(NPT)));
                v = $rtoi(x + 0.5);
                tab_m[j] = (v > YMAX) ? YMAX : v;
            end
        end

        // Reset held with ival = 1 and the clock enabled.
        #1;
        ireset  = 1'b0;
        ival    = 1'b1;
        iclkena = 1'b1;
        iaddr   = 32'h1234_8000;
        for (int c = 0; c < 3; c++) begin
            @(negedge iclk);
            check("rst_oval", int'(oval), 0);
            check("rst_odat", int'(odat), 0);
            check("rst_osat", int'(osat), 0);
        end

        // Release together with the first directed vector.
        @(posedge iclk);
        #2;
        ireset = 1'b1;
        apply(1'b1, 1'b1, 16'h0000, 16'h8000, 1'b1);
        drive(1'b1, 1'b1, 16'h8000, 16'hFFFF, 1'b1);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFF80, 1'b1);
        drive(1'b1, 1'b1, 16'hFF80, 16'h0000, 1'b1);
        drive(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);

        // Full sweep, channel 1 runs in the opposite direction.
        for (int k = 0; k < 65536; k++)
            drive(1'b1, 1'b1, k, k ^ 16'hFFFF, 1'b0);

        // Random enable/valid with one mid-stream reset.
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                @(posedge iclk);
                #2;
                ireset = 1'b0;
                q.delete();
                #1;
                check("mid_rst_oval", int'(oval), 0);
                check("mid_rst_odat", int'(odat), 0);
                drive(1'b1, 1'b1, $urandom_range(0, 65535), $urandom_range(0, 65535), 1'b0);
                @(posedge iclk);
                #2;
                ireset = 1'b1;
                apply(1'b1, 1'b1, $urandom_range(0, 65535), $urandom_range(0, 65535), 1'b0);
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 65535), $urandom_range(0, 65535), 1'b0);
            end
        end

        // Drain with a bounded wait.
        for (int c = 0; c < 40 && q.size() > 0; c++)
            drive(1'b0, 1'b1, 0, 0, 1'b0);
        check("drain_left", q.size(), 0);
        repeat (6) drive(1'b0, 1'b1, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
